// File: rtl/decode_stage.sv
// Decode stage: latches fetch word/PC, reads regfile, resolves BEQ/J, issues micro-fields to EX.
// Latency: one register stage (DR at cycle N shows on ex_* after the following posedge).
// Backpressure: load-use hazard drops enbl for one cycle; taken BEQ/J pulses dec and discards one slot.
// Optional: define REGFILE_BYPASS_EN for write-first register reads.
module decode_stage #(
  parameter int PC_W = 7,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     DR,
  input  logic [PC_W-1:0] pc_in,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            dec,
  output logic [PC_W-1:0] pc_mux,
  output logic            enbl,
  output logic            ex_valid,
  output logic [5:0]      ex_opcode,
  output logic [5:0]      ex_funct,
  output logic [31:0]     ex_rs_val,
  output logic [31:0]     ex_rt_val,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_wreg,
  output logic            ex_wen,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [1:0] {RUN, STALL, REDIRECT} state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [PC_W-1:0] pcr;
  logic [31:0]     regs [NREG];

  logic [31:0]     src;
  logic [PC_W-1:0] src_pc;
  logic [5:0]      op;
  logic [4:0]      rs_idx, rt_idx, rd_idx;
  logic [31:0]     rs_val, rt_val;
  logic            is_r, is_addi, is_lw, is_sw, is_beq, is_j;
  logic            d_valid, reads_rs, reads_rt;
  logic            hazard, taken, issue;
  logic [PC_W-1:0] target;

  // A stalled instruction is re-decoded from the held IR; otherwise decode the live fetch word
  always_comb begin
    src    = (state == STALL) ? ir  : DR;
    src_pc = (state == STALL) ? pcr : pc_in;
    op     = src[31:26];
    rs_idx = src[25:21];
    rt_idx = src[20:16];
    rd_idx = src[15:11];
  end

  // Register file reads; index 0 is hard zero, optional write-first bypass from writeback
  always_comb begin
    rs_val = (rs_idx == 5'd0) ? 32'd0 : regs[rs_idx];
    rt_val = (rt_idx == 5'd0) ? 32'd0 : regs[rt_idx];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && wb_addr == rs_idx) rs_val = wb_data;
    if (wb_we && wb_addr != 5'd0 && wb_addr == rt_idx) rt_val = wb_data;
`endif
  end

  // Instruction classification, load-use detection and branch resolution
  always_comb begin
    is_r     = (op == OP_R) && (src != 32'd0);
    is_addi  = (op == OP_ADDI);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_j     = (op == OP_J);
    d_valid  = is_r | is_addi | is_lw | is_sw;
    reads_rs = d_valid | is_beq;
    reads_rt = is_r | is_sw | is_beq;
    // Only a live RUN-state decode can collide with a load sitting in EX
    hazard   = (state == RUN) && ex_mem_rd && (ex_wreg != 5'd0) &&
               ((reads_rs && rs_idx == ex_wreg) || (reads_rt && rt_idx == ex_wreg));
    taken    = is_j | (is_beq && rs_val == rt_val);
    target   = is_j ? src[PC_W-1:0] : src_pc + src[PC_W-1:0];
    issue    = ((state == RUN) && !hazard) || (state == STALL);
  end

  // Register file write port; cleared on reset, r0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 32'd0;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Control FSM with registered redirect/enable lines and EX issue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      ir        <= 32'd0;
      pcr       <= '0;
      dec       <= 1'b0;
      pc_mux    <= '0;
      enbl      <= 1'b1;
      ex_valid  <= 1'b0;
      ex_opcode <= 6'd0;
      ex_funct  <= 6'd0;
      ex_rs_val <= 32'd0;
      ex_rt_val <= 32'd0;
      ex_imm    <= 32'd0;
      ex_wreg   <= 5'd0;
      ex_wen    <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
    end else begin
      // Every slot defaults to a bubble with fetch enabled and no redirect
      dec       <= 1'b0;
      enbl      <= 1'b1;
      ex_valid  <= 1'b0;
      ex_opcode <= 6'd0;
      ex_funct  <= 6'd0;
      ex_rs_val <= 32'd0;
      ex_rt_val <= 32'd0;
      ex_imm    <= 32'd0;
      ex_wreg   <= 5'd0;
      ex_wen    <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;

      if (state == RUN) begin
        ir  <= DR;
        pcr <= pc_in;
      end

      if (state == RUN && hazard) begin
        enbl  <= 1'b0;
        state <= STALL;
      end else if (state == REDIRECT) begin
        state <= RUN;
      end

      if (issue) begin
        if (d_valid) begin
          ex_valid  <= 1'b1;
          ex_opcode <= op;
          ex_funct  <= src[5:0];
          ex_rs_val <= rs_val;
          ex_rt_val <= rt_val;
          ex_imm    <= {{16{src[15]}}, src[15:0]};
          ex_wreg   <= is_r ? rd_idx : ((is_addi | is_lw) ? rt_idx : 5'd0);
          ex_wen    <= is_r | is_addi | is_lw;
          ex_mem_rd <= is_lw;
          ex_mem_wr <= is_sw;
        end
        if (taken) begin
          dec    <= 1'b1;
          pc_mux <= target;
          state  <= REDIRECT;
        end else begin
          state  <= RUN;
        end
      end
    end
  end

endmodule
